// File: rtl/pe_stream_arbiter_pkg.sv
// Shared definitions for the PE stream arbiter: FSM encoding and default sizing.
package pe_stream_arbiter_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  localparam int DEF_AXIS_WIDTH = 128;
  localparam int DEF_MAX_BURST  = 16;

endpackage

// File: rtl/pe_stream_arbiter_rr_pick.sv
// Round-robin search: first set bit of req starting just after index last.
module rr_pick
  import pe_stream_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] idx,
  output logic         found
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      int c;
      c = (int'(last) + k) % N;
      if (req[c[IW-1:0]]) begin
        idx   = W'(c);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_stream_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ valid/ready streams onto one registered output.
//   state    | meaning
//   ST_ARB   | no owner; pick next requester round-robin, all req_ready low
//   ST_BURST | requester last_grant owns the output until last beat or MAX_BURST beats
module pe_stream_arbiter
  import pe_stream_arbiter_pkg::*;
#(
  parameter int AXIS_WIDTH = DEF_AXIS_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ap_start,
  input  logic [NUM_REQ*AXIS_WIDTH-1:0] req_din,
  input  logic [NUM_REQ-1:0]            req_val,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [AXIS_WIDTH-1:0]         dout,
  output logic                          val_out,
  output logic                          last_out,
  output logic [ID_WIDTH-1:0]           grant_id,
  input  logic                          ready_downward
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t            state, state_n;
  logic [ID_WIDTH-1:0]   last_grant, last_grant_n;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_found;
  logic [CNT_W-1:0]      beat_cnt, beat_cnt_n;
  logic                  can_load;
  logic                  accept;
  logic                  sel_val;
  logic                  sel_last;
  logic [AXIS_WIDTH-1:0] sel_din;

  rr_pick #(
    .N(NUM_REQ),
    .W(ID_WIDTH)
  ) u_rr_pick (
    .req  (req_val),
    .last (last_grant),
    .idx  (pick_idx),
    .found(pick_found)
  );

  // last_grant doubles as the current owner while in ST_BURST.
  always_comb begin
    sel_val  = 1'b0;
    sel_last = 1'b0;
    sel_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last_grant == ID_WIDTH'(i)) begin
        sel_val  = req_val[i];
        sel_last = req_last[i];
        sel_din  = req_din[i*AXIS_WIDTH +: AXIS_WIDTH];
      end
    end
  end

  assign can_load = ap_start & (~val_out | ready_downward);
  assign accept   = (state == ST_BURST) & can_load & sel_val;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == ST_BURST) & can_load & (last_grant == ID_WIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_ARB;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      beat_cnt   <= beat_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    beat_cnt_n   = beat_cnt;
    if (ap_start) begin
      case (state)
        ST_ARB: begin
          if (pick_found) begin
            state_n      = ST_BURST;
            last_grant_n = pick_idx;
            beat_cnt_n   = '0;
          end
        end
        ST_BURST: begin
          if (accept) begin
            beat_cnt_n = beat_cnt + CNT_W'(1);
            if (sel_last || (beat_cnt_n == CNT_W'(MAX_BURST))) begin
              state_n = ST_ARB;
            end
          end
        end
        default: state_n = ST_ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout     <= '0;
      val_out  <= 1'b0;
      last_out <= 1'b0;
      grant_id <= '0;
    end else if (accept) begin
      dout     <= sel_din;
      val_out  <= 1'b1;
      last_out <= sel_last;
      grant_id <= last_grant;
    end else if (ap_start && ready_downward) begin
      val_out <= 1'b0;
    end
  end

endmodule
